pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter CNT_W, default 16: width of the redirect performance counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 boot_i  input  1  start fetching; sampled only in IDLE.
REQ-006 stall_i  input  1  hazard stall from decode; holds PC.
REQ-007 imem_ready_i  input  1  instruction memory accepts the current fetch request.
REQ-008 ex_valid_i  input  1  EX-stage instruction valid.
REQ-009 ex_taken_br_i  input  1  conditional branch taken, from branch unit.
REQ-010 ex_is_jal_i / ex_is_jalr_i  input  1 each  unconditional jump decode.
REQ-011 ex_br_tgt_pc_i  input  32  pc+imm from branch unit.
REQ-012 ex_jalr_tgt_pc_i  input  32  rs1+imm from branch unit.
REQ-013 trap_clr_i  input  1  software/debug acknowledge of a misaligned-target trap.
REQ-014 fetch_req_o  output  1  fetch request valid.
REQ-015 pc_o  output  32  fetch address.
REQ-016 flush_o  output  1  kill IF/ID contents this cycle.
REQ-017 trap_o  output  1  misaligned redirect target pending.
REQ-018 trap_pc_o  output  32  offending target address.
REQ-019 redirect_cnt_o  output  CNT_W  number of accepted redirects.

Function
REQ-020 FSM states IDLE, RUN, TRAP; reset state IDLE.
REQ-021 IDLE: fetch_req_o=0; IDLE->RUN on boot_i=1, pc_o unchanged.
REQ-022 RUN: fetch_req_o=1; fetch accepted when fetch_req_o & imem_ready_i & !stall_i, then pc <= pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-023 redirect = ex_valid_i & (ex_taken_br_i | ex_is_jal_i | ex_is_jalr_i), evaluated only in RUN.
REQ-024 Target: ex_is_jalr_i -> {ex_jalr_tgt_pc_i[31:1],1'b0}; otherwise ex_br_tgt_pc_i.
REQ-025 Redirect with target[1:0]==0: pc <= target next edge, regardless of stall_i and imem_ready_i; pending unaccepted request is abandoned.
REQ-026 flush_o = redirect in RUN, combinational, same cycle (also asserted for misaligned redirect).
REQ-027 Redirect with target[1:0]!=0: RUN->TRAP, trap_pc_o <= target, pc_o held, no pc update.
REQ-028 TRAP: fetch_req_o=0, trap_o=1, redirect inputs ignored; trap_clr_i -> RUN resuming at held pc_o.
REQ-029 redirect_cnt_o increments by 1 per aligned redirect, saturates at all-ones.
REQ-030 Simultaneous redirect and fetch acceptance: redirect wins, no +4 applied.
REQ-031 stall_i with no redirect: pc_o, fetch_req_o held stable.

Reset
REQ-032 rst_n low: state IDLE, pc_o=RESET_PC, fetch_req_o=0, flush_o=0, trap_o=0, trap_pc_o=0, redirect_cnt_o=0, asynchronously.
REQ-033 Reset mid-redirect or in TRAP discards all pending state; no redirect survives reset.

Structure
REQ-034 FSM state encoding, RESET_PC default and instruction-size constant (4) reside in the shared core package.
REQ-035 Single module; branch unit remains a separate instance feeding ex_* inputs; no sub-module required.

Verification
REQ-036 Reset RESET_PC=32'h100, boot_i pulse, imem_ready_i=1 -> pc_o 100,104,108 on consecutive cycles.
REQ-037 pc_o=32'h120, ex_taken_br_i=1, ex_br_tgt_pc_i=32'h80, stall_i=1 -> flush_o=1 same cycle, pc_o=80 next cycle, redirect_cnt_o=1.
REQ-038 ex_is_jalr_i=1, ex_jalr_tgt_pc_i=32'h203 -> pc_o=32'h202? No: target 202 misaligned ([1:0]=10) -> TRAP, trap_pc_o=32'h202, fetch_req_o=0; trap_clr_i -> RUN at held pc.
REQ-039 imem_ready_i=0 for 3 cycles at pc 32'h40 -> pc_o stays 40; ready=1 -> 44.
REQ-040 pc_o=32'hFFFF_FFFC, accepted fetch -> pc_o=0.
REQ-041 rst_n asserted in TRAP with redirect_cnt_o=5 -> IDLE, counter 0, trap_o 0 immediately.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared core definitions for the fetch PC sequencer: state encoding and
// architectural constants.
package pc_sequencer_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } pc_state_e;

endpackage : pc_sequencer_pkg

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential fetch, branch/jump redirect with flush,
// misaligned-target trap and a saturating redirect counter.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             boot_i,
    input  logic             stall_i,
    input  logic             imem_ready_i,
    input  logic             ex_valid_i,
    input  logic             ex_taken_br_i,
    input  logic             ex_is_jal_i,
    input  logic             ex_is_jalr_i,
    input  logic [31:0]      ex_br_tgt_pc_i,
    input  logic [31:0]      ex_jalr_tgt_pc_i,
    input  logic             trap_clr_i,
    output logic             fetch_req_o,
    output logic [31:0]      pc_o,
    output logic             flush_o,
    output logic             trap_o,
    output logic [31:0]      trap_pc_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    pc_state_e        state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      trap_pc_q, trap_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_req_q;
    logic             trap_q;

    logic             redirect;
    logic [31:0]      target;

    // JALR targets have bit 0 cleared; everything else uses pc+imm.
    assign redirect = ex_valid_i & (ex_taken_br_i | ex_is_jal_i | ex_is_jalr_i);
    assign target   = ex_is_jalr_i ? (ex_jalr_tgt_pc_i & ~32'h0000_0001)
                                   : ex_br_tgt_pc_i;

    // Next-state, next-PC and combinational flush.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        trap_pc_d = trap_pc_q;
        cnt_d     = cnt_q;
        flush_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (boot_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    flush_o = 1'b1;
                    if (target[1:0] == 2'b00) begin
                        pc_d = target;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d   = ST_TRAP;
                        trap_pc_d = target;
                    end
                end else if (imem_ready_i && !stall_i) begin
                    pc_d = pc_q + 32'(INSTR_BYTES);
                end
            end
            ST_TRAP: begin
                if (trap_clr_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; fetch_req/trap flags follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            trap_pc_q   <= 32'h0000_0000;
            cnt_q       <= '0;
            fetch_req_q <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            trap_pc_q   <= trap_pc_d;
            cnt_q       <= cnt_d;
            fetch_req_q <= (state_d == ST_RUN);
            trap_q      <= (state_d == ST_TRAP);
        end
    end

    assign fetch_req_o    = fetch_req_q;
    assign pc_o           = pc_q;
    assign trap_o         = trap_q;
    assign trap_pc_o      = trap_pc_q;
    assign redirect_cnt_o = cnt_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural reference model checked
// every cycle, plus hand-computed literal checkpoints.
module tb_pc_sequencer;

    localparam logic [31:0] RPC     = 32'h0000_0100;
    localparam int unsigned CW      = 3;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          boot_i, stall_i, imem_ready_i;
    logic          ex_valid_i, ex_taken_br_i, ex_is_jal_i, ex_is_jalr_i;
    logic [31:0]   ex_br_tgt_pc_i, ex_jalr_tgt_pc_i;
    logic          trap_clr_i;
    logic          fetch_req_o, flush_o, trap_o;
    logic [31:0]   pc_o, trap_pc_o;
    logic [CW-1:0] redirect_cnt_o;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = idle, 1 = running, 2 = trapped.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_trap_pc;
    int          m_cnt;

    pc_sequencer #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .boot_i           (boot_i),
        .stall_i          (stall_i),
        .imem_ready_i     (imem_ready_i),
        .ex_valid_i       (ex_valid_i),
        .ex_taken_br_i    (ex_taken_br_i),
        .ex_is_jal_i      (ex_is_jal_i),
        .ex_is_jalr_i     (ex_is_jalr_i),
        .ex_br_tgt_pc_i   (ex_br_tgt_pc_i),
        .ex_jalr_tgt_pc_i (ex_jalr_tgt_pc_i),
        .trap_clr_i       (trap_clr_i),
        .fetch_req_o      (fetch_req_o),
        .pc_o             (pc_o),
        .flush_o          (flush_o),
        .trap_o           (trap_o),
        .trap_pc_o        (trap_pc_o),
        .redirect_cnt_o   (redirect_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_jump();
        return ex_valid_i && (ex_taken_br_i || ex_is_jal_i || ex_is_jalr_i);
    endfunction

    function automatic logic [31:0] m_target();
        if (ex_is_jalr_i) return ex_jalr_tgt_pc_i - (ex_jalr_tgt_pc_i % 2);
        return ex_br_tgt_pc_i;
    endfunction

    // Reference model of the architectural behaviour.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode    <= 0;
            m_pc      <= RPC;
            m_trap_pc <= 32'h0;
            m_cnt     <= 0;
        end else if (m_mode == 0) begin
            if (boot_i) m_mode <= 1;
        end else if (m_mode == 1) begin
            if (m_jump()) begin
                if (m_target() % 4 == 0) begin
                    m_pc <= m_target();
                    if (m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
                end else begin
                    m_mode    <= 2;
                    m_trap_pc <= m_target();
                end
            end else if (imem_ready_i && !stall_i) begin
                m_pc <= m_pc + 32'd4;
            end
        end else begin
            if (trap_clr_i) m_mode <= 1;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("fetch_req", 32'(fetch_req_o), 32'(m_mode == 1));
            chk("pc", pc_o, m_pc);
            chk("flush", 32'(flush_o), 32'(m_mode == 1 && m_jump()));
            chk("trap", 32'(trap_o), 32'(m_mode == 2));
            chk("trap_pc", trap_pc_o, m_trap_pc);
            chk("redirect_cnt", 32'(redirect_cnt_o), 32'(m_cnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_ex();
        ex_valid_i    = 1'b0;
        ex_taken_br_i = 1'b0;
        ex_is_jal_i   = 1'b0;
        ex_is_jalr_i  = 1'b0;
    endtask

    task automatic branch(input logic [31:0] tgt);
        ex_valid_i     = 1'b1;
        ex_taken_br_i  = 1'b1;
        ex_br_tgt_pc_i = tgt;
        tick(1);
        clear_ex();
    endtask

    initial begin
        rst_n = 1'b0;
        boot_i = 1'b0; stall_i = 1'b0; imem_ready_i = 1'b0; trap_clr_i = 1'b0;
        ex_br_tgt_pc_i = 32'h0; ex_jalr_tgt_pc_i = 32'h0;
        clear_ex();
        tick(2);
        chk("rst_pc", pc_o, 32'h100);
        chk("rst_fetch_req", 32'(fetch_req_o), 32'h0);
        chk("rst_cnt", 32'(redirect_cnt_o), 32'h0);
        chk("rst_trap_pc", trap_pc_o, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Boot and sequential fetch.
        boot_i = 1'b1; imem_ready_i = 1'b1;
        tick(1);
        boot_i = 1'b0;
        chk("boot_pc", pc_o, 32'h100);
        chk("boot_fetch_req", 32'(fetch_req_o), 32'h1);
        tick(1);
        chk("seq_pc1", pc_o, 32'h104);
        tick(1);
        chk("seq_pc2", pc_o, 32'h108);

        // Memory not ready holds the PC.
        branch(32'h40);
        imem_ready_i = 1'b0;
        tick(3);
        chk("not_ready_pc", pc_o, 32'h40);
        imem_ready_i = 1'b1;
        tick(1);
        chk("ready_pc", pc_o, 32'h44);

        // Redirect under stall flushes and wins.
        branch(32'h120);
        stall_i = 1'b1;
        ex_valid_i = 1'b1; ex_taken_br_i = 1'b1; ex_br_tgt_pc_i = 32'h80;
        #1;
        chk("stall_redir_flush", 32'(flush_o), 32'h1);
        tick(1);
        clear_ex();
        chk("stall_redir_pc", pc_o, 32'h80);
        chk("stall_redir_cnt", 32'(redirect_cnt_o), 32'h3);
        tick(2);
        chk("stall_hold_pc", pc_o, 32'h80);
        stall_i = 1'b0;

        // Taken flag without valid is not a redirect.
        ex_taken_br_i = 1'b1; ex_br_tgt_pc_i = 32'h500;
        tick(1);
        clear_ex();
        chk("invalid_ex_pc", pc_o, 32'h84);

        // Address wrap.
        branch(32'hFFFF_FFFC);
        tick(1);
        chk("wrap_pc", pc_o, 32'h0);

        // JAL with accepted fetch: no +4 on top of the target.
        ex_valid_i = 1'b1; ex_is_jal_i = 1'b1;
        ex_br_tgt_pc_i = 32'h300; ex_jalr_tgt_pc_i = 32'h777;
        tick(1);
        clear_ex();
        chk("jal_pc", pc_o, 32'h300);
        chk("jal_cnt", 32'(redirect_cnt_o), 32'h5);

        // Misaligned JALR target traps.
        ex_valid_i = 1'b1; ex_is_jalr_i = 1'b1; ex_jalr_tgt_pc_i = 32'h203;
        #1;
        chk("mis_flush", 32'(flush_o), 32'h1);
        tick(1);
        clear_ex();
        chk("mis_trap", 32'(trap_o), 32'h1);
        chk("mis_trap_pc", trap_pc_o, 32'h202);
        chk("mis_fetch_req", 32'(fetch_req_o), 32'h0);
        chk("mis_pc_held", pc_o, 32'h300);

        // Redirects ignored while trapped.
        ex_valid_i = 1'b1; ex_taken_br_i = 1'b1; ex_br_tgt_pc_i = 32'h40;
        #1;
        chk("trap_no_flush", 32'(flush_o), 32'h0);
        tick(1);
        clear_ex();
        chk("trap_ignore_pc", pc_o, 32'h300);
        trap_clr_i = 1'b1;
        tick(1);
        trap_clr_i = 1'b0;
        chk("clr_fetch_req", 32'(fetch_req_o), 32'h1);
        chk("clr_pc", pc_o, 32'h300);
        tick(1);
        chk("resume_pc", pc_o, 32'h304);

        // Reset while trapped clears everything immediately.
        ex_valid_i = 1'b1; ex_is_jalr_i = 1'b1; ex_jalr_tgt_pc_i = 32'h203;
        tick(1);
        clear_ex();
        chk("pre_rst_cnt", 32'(redirect_cnt_o), 32'h5);
        chk("pre_rst_trap", 32'(trap_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_trap", 32'(trap_o), 32'h0);
        chk("async_rst_cnt", 32'(redirect_cnt_o), 32'h0);
        chk("async_rst_pc", pc_o, 32'h100);
        chk("async_rst_fetch", 32'(fetch_req_o), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_idle", 32'(fetch_req_o), 32'h0);

        // Aligned JALR (bit 0 dropped) and counter saturation.
        boot_i = 1'b1;
        tick(1);
        boot_i = 1'b0;
        ex_valid_i = 1'b1; ex_is_jalr_i = 1'b1; ex_jalr_tgt_pc_i = 32'h401;
        tick(1);
        clear_ex();
        chk("jalr_pc", pc_o, 32'h400);
        for (int i = 1; i <= 8; i++) begin
            branch(32'(i * 16));
        end
        chk("sat_cnt", 32'(redirect_cnt_o), 32'h7);
        chk("sat_pc", pc_o, 32'h80);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_sequencer
